// File: rtl/rnn_pkg.sv
// Shared constants, state encoding and width helpers for the RNN frame sequencer.
package rnn_pkg;

    localparam int RNN_FIXED   = 32;
    localparam int RNN_N_FEAT  = 42;
    localparam int RNN_N_GAIN  = 22;
    localparam int RNN_LAT_DEF = 4;

    // Sequencer states: LOAD takes words, DROP discards the tail of an overlong
    // frame, WAIT holds the bus for the core, OUT presents the result.
    typedef enum logic [1:0] {
        LOAD = 2'd0,
        DROP = 2'd1,
        WAIT = 2'd2,
        OUT  = 2'd3
    } seq_state_t;

    // Width helpers; never below one bit so degenerate sizes still elaborate.
    function automatic int idx_width(input int n_feat);
        return (n_feat > 1) ? $clog2(n_feat) : 1;
    endfunction

    function automatic int lat_width(input int latency);
        return (latency > 0) ? $clog2(latency + 1) : 1;
    endfunction

    localparam int RNN_IDX_W = idx_width(RNN_N_FEAT);
    localparam int RNN_LAT_W = lat_width(RNN_LAT_DEF);

endpackage

// File: rtl/rnn_feat_buffer.sv
// Indexed write-enable register file that drives the packed RNN feature bus.
module rnn_feat_buffer
    import rnn_pkg::*;
#(
    parameter int FIXED  = RNN_FIXED,
    parameter int N_FEAT = RNN_N_FEAT,
    parameter int IDX_W  = idx_width(N_FEAT)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    we,
    input  logic [IDX_W-1:0]        idx,
    input  logic [FIXED-1:0]        data,
    output logic [N_FEAT*FIXED-1:0] feature
);

    logic [N_FEAT-1:0][FIXED-1:0] words;

    for (genvar i = 0; i < N_FEAT; i++) begin : g_word
        // Each word only changes when its own index is written; otherwise holds.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                words[i] <= '0;
            else if (we && (idx == IDX_W'(i)))
                words[i] <= data;
        end
    end

    // Word i lands at bits [i*FIXED +: FIXED].
    assign feature = words;

endmodule

// File: rtl/rnn_frame_sequencer.sv
// Streams one frame of features onto the RNN bus, waits out the core latency,
// captures gains/VAD and hands them downstream over valid/ready.
module rnn_frame_sequencer
    import rnn_pkg::*;
#(
    parameter int FIXED       = RNN_FIXED,
    parameter int N_FEAT      = RNN_N_FEAT,
    parameter int N_GAIN      = RNN_N_GAIN,
    parameter int RNN_LATENCY = RNN_LAT_DEF,
    parameter int CNT_W       = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [FIXED-1:0]        s_data,
    input  logic                    s_last,
    output logic [N_FEAT*FIXED-1:0] feature,
    input  logic [N_GAIN*FIXED-1:0] rnn_gains,
    input  logic [FIXED-1:0]        rnn_vad,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [N_GAIN*FIXED-1:0] gains,
    output logic [FIXED-1:0]        vad,
    output logic                    frame_err,
    output logic [CNT_W-1:0]        frame_cnt
);

    localparam int IDX_W = idx_width(N_FEAT);
    localparam int LAT_W = lat_width(RNN_LATENCY);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_FEAT - 1);
    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(RNN_LATENCY - 1);

    seq_state_t       state, next_state;
    logic [IDX_W-1:0] idx;
    logic [LAT_W-1:0] lat_cnt;

    logic load_hs, at_last, good_end, capture, out_hs;

    assign load_hs  = (state == LOAD) && s_valid;
    assign at_last  = (idx == IDX_LAST);
    assign good_end = load_hs && s_last && at_last;
    assign capture  = (state == WAIT) && (lat_cnt == '0);
    assign out_hs   = (state == OUT) && m_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= LOAD;
        else
            state <= next_state;
    end

    // Next-state logic; a malformed frame either stays in LOAD (short) or
    // diverts to DROP until the upstream's s_last (long).
    always_comb begin
        next_state = state;
        unique case (state)
            LOAD: if (load_hs) begin
                if (s_last)
                    next_state = at_last ? WAIT : LOAD;
                else if (at_last)
                    next_state = DROP;
            end
            DROP: if (s_valid && s_last) next_state = LOAD;
            WAIT: if (capture)           next_state = OUT;
            OUT:  if (m_ready)           next_state = LOAD;
            default:                     next_state = LOAD;
        endcase
    end

    // State-decoded outputs: input is accepted while loading or draining.
    always_comb begin
        s_ready = (state == LOAD) || (state == DROP);
    end

    // Word index: advances within a frame, restarts on any frame end or error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            idx <= '0;
        else if (load_hs)
            idx <= (!s_last && !at_last) ? idx + 1'b1 : '0;
    end

    // Latency counter: armed on the last good word, counts down in WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            lat_cnt <= '0;
        else if (good_end)
            lat_cnt <= LAT_INIT;
        else if ((state == WAIT) && (lat_cnt != '0))
            lat_cnt <= lat_cnt - 1'b1;
    end

    // Error pulse when the s_last position disagrees with the frame length.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            frame_err <= 1'b0;
        else
            frame_err <= load_hs && (s_last != at_last);
    end

    // Result registers: sample the core only at the end of WAIT, hold in OUT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gains     <= '0;
            vad       <= '0;
            m_valid   <= 1'b0;
            frame_cnt <= '0;
        end else if (capture) begin
            gains   <= rnn_gains;
            vad     <= rnn_vad;
            m_valid <= 1'b1;
        end else if (out_hs) begin
            m_valid   <= 1'b0;
            frame_cnt <= frame_cnt + 1'b1;
        end
    end

    rnn_feat_buffer #(
        .FIXED  (FIXED),
        .N_FEAT (N_FEAT),
        .IDX_W  (IDX_W)
    ) u_feat_buffer (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (load_hs),
        .idx     (idx),
        .data    (s_data),
        .feature (feature)
    );

endmodule

// File: tb/tb_rnn_frame_sequencer.sv
// Directed bench for rnn_frame_sequencer with a behavioural RNN stand-in.
module tb_rnn_frame_sequencer;

    localparam int FIXED  = 32;
    localparam int N_FEAT = 42;
    localparam int N_GAIN = 22;
    localparam int LAT    = 4;
    localparam int CNT_W  = 2;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    s_valid, s_ready, s_last, m_valid, m_ready, frame_err;
    logic [FIXED-1:0]        s_data, vad, rnn_vad;
    logic [N_FEAT*FIXED-1:0] feature;
    logic [N_GAIN*FIXED-1:0] rnn_gains, gains;
    logic [CNT_W-1:0]        frame_cnt;

    int n_vec = 0;
    int n_err = 0;
    int err_cnt = 0;
    int mv_rise = 0;
    logic mv_q = 1'b0;

    always #5 clk = ~clk;

    rnn_frame_sequencer #(
        .FIXED(FIXED), .N_FEAT(N_FEAT), .N_GAIN(N_GAIN),
        .RNN_LATENCY(LAT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .feature(feature), .rnn_gains(rnn_gains), .rnn_vad(rnn_vad),
        .m_valid(m_valid), .m_ready(m_ready), .gains(gains), .vad(vad),
        .frame_err(frame_err), .frame_cnt(frame_cnt)
    );

    // RNN stand-in: gain k = word0 + 1 + k, vad = word41 + 0x100.
    always_comb begin
        rnn_gains = '0;
        for (int k = 0; k < N_GAIN; k++)
            rnn_gains[k*FIXED +: FIXED] = feature[FIXED-1:0] + 32'(1 + k);
        rnn_vad = feature[(N_FEAT-1)*FIXED +: FIXED] + 32'h100;
    end

    // Event monitors sampled on the falling edge.
    always @(negedge clk) begin
        if (frame_err) err_cnt++;
        if (m_valid && !mv_q) mv_rise++;
        mv_q = m_valid;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] fw(input int i);
        return feature[i*FIXED +: FIXED];
    endfunction

    function automatic logic [31:0] gw(input int i);
        return gains[i*FIXED +: FIXED];
    endfunction

    // Send words base+1..base+n, s_last on word n. Returns just after the last handshake edge.
    task automatic send_frame(input logic [31:0] base, input int n);
        for (int i = 1; i <= n; i++) begin
            int guard;
            @(negedge clk);
            s_valid = 1'b1;
            s_data  = base + 32'(i);
            s_last  = (i == n);
            guard = 0;
            while (!s_ready && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 100) chk("s_ready_timeout", 32'(s_ready), 32'd1);
            @(posedge clk);
        end
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // Count falling edges until m_valid, starting right after the last handshake edge.
    task automatic wait_result(output int lat);
        @(negedge clk);
        lat = 0;
        while (!m_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // Check presented result, hold it under backpressure, then hand it off.
    task automatic take_result(input logic [31:0] base, input int hold, input logic [1:0] cnt_exp);
        int bad;
        chk("m_valid", 32'(m_valid), 32'd1);
        chk("gain0", gw(0), base + 32'd2);
        chk("gain21", gw(21), base + 32'd23);
        chk("vad", vad, base + 32'h12A);
        bad = 0;
        m_ready = 1'b0;
        for (int c = 0; c < hold; c++) begin
            @(negedge clk);
            if (gw(0) !== base + 32'd2 || vad !== base + 32'h12A || s_ready !== 1'b0 ||
                m_valid !== 1'b1 || frame_cnt !== cnt_exp - 2'd1) bad++;
        end
        if (hold > 0) chk("hold_stable", 32'(bad), 32'd0);
        m_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        m_ready = 1'b0;
        chk("m_valid_drop", 32'(m_valid), 32'd0);
        chk("frame_cnt", 32'(frame_cnt), 32'(cnt_exp));
        chk("s_ready_after", 32'(s_ready), 32'd1);
    endtask

    task automatic good_frame(input logic [31:0] base, input int hold, input logic [1:0] cnt_exp);
        int lat;
        send_frame(base, N_FEAT);
        wait_result(lat);
        chk("latency", 32'(lat), 32'(LAT));
        chk("feat0", fw(0), base + 32'd1);
        chk("feat41", fw(41), base + 32'h2A);
        take_result(base, hold, cnt_exp);
    endtask

    task automatic bad_frame(input logic [31:0] base, input int n);
        int e0, m0;
        e0 = err_cnt;
        m0 = mv_rise;
        send_frame(base, n);
        repeat (10) @(negedge clk);
        chk("err_pulse", 32'(err_cnt - e0), 32'd1);
        chk("no_m_valid", 32'(mv_rise - m0), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_s_ready", 32'(s_ready), 32'd1);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_feature", 32'(|feature), 32'd0);
        chk("rst_gains", 32'(|gains), 32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);

        // Nominal, then backpressure.
        good_frame(32'h0, 0, 2'd1);
        good_frame(32'h100, 10, 2'd2);

        // Short frame then recovery with index restarted.
        bad_frame(32'h200, 20);
        chk("short_feat19", fw(19), 32'h214);
        good_frame(32'h300, 0, 2'd3);

        // Long frame: word 42 was written, 43-45 dropped; then recovery.
        bad_frame(32'h400, 45);
        chk("long_feat41", fw(41), 32'h42A);
        good_frame(32'h500, 0, 2'd0);

        // Reset two cycles into WAIT.
        send_frame(32'h600, N_FEAT);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_m_valid", 32'(m_valid), 32'd0);
        chk("mid_rst_feature", 32'(|feature), 32'd0);
        chk("mid_rst_frame_cnt", 32'(frame_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_s_ready", 32'(s_ready), 32'd1);
        chk("mid_rst_no_result", 32'(m_valid), 32'd0);

        // Counter wrap: 1,2,3,0,1.
        good_frame(32'h700, 0, 2'd1);
        good_frame(32'h800, 0, 2'd2);
        good_frame(32'h900, 0, 2'd3);
        good_frame(32'hA00, 0, 2'd0);
        good_frame(32'hB00, 0, 2'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
